cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Return side of the issue/dispatch path: collects completed results from the functional units (UA addSub, others).
//  Buffers them, picks the oldest and broadcasts one per cycle on the 19-bit Common Data Bus.
//  CDB = {tag[2:0], data[15:0]}; reservation stations (tags 1..4) and registerFile snoop it.
//  Tag 0 means "no broadcast" (same encoding as "no dependency" in registerFile).
// PARAMETERS
//  N_SRC   2   number of functional-unit result sources
//  DEPTH   2   entries per source FIFO (power of 2, >=2)
//  TAG_W   3   reservation-station tag width
//  DATA_W  16  result data width
//  AGE_W   10  issue-counter width (age of producing instruction)
// PORTS
//  CLK       in   1               clock, rising edge
//  CLR       in   1               reset, asynchronous, active-high
//  req       in   N_SRC           per-source result valid (one-cycle push)
//  req_tag   in   N_SRC*TAG_W     per-source destination tag, source i at [i*TAG_W +: TAG_W]
//  req_data  in   N_SRC*DATA_W    per-source result data
//  req_age   in   N_SRC*AGE_W     per-source issue counter of the producing instruction
//  full      out  N_SRC           source FIFO full; source must not assert req while high
//  conf      out  N_SRC           one-cycle pulse: this source's head was broadcast this cycle
//  CDB       out  TAG_W+DATA_W    {tag,data}; registered; tag 0 when idle
//  ovf       out  1               sticky: a push was dropped (req while full)
// BEHAVIOUR
//  Reset: FIFOs empty, CDB=0, conf=0, ovf=0; full=0 combinationally from empty FIFOs.
//    CLR mid-operation discards all buffered results.
//  Push: at a CLK edge with req[i]=1, tag!=0 and !full[i], {tag,data,age} enters FIFO i.
//    req with tag==0 is ignored silently.
//    req while full[i] is dropped and sets ovf (cleared only by CLR).
//  full[i] is computed from occupancy before this edge's pop.
//    A push into a full FIFO is dropped even if that FIFO pops on the same edge.
//  Select: combinational over non-empty FIFO heads; winner = oldest age.
//    Age compare is wrap-aware: a older than b iff (a-b) mod 2^AGE_W has MSB set.
//    Equal ages: lowest source index wins.
//  Pop/broadcast: at each edge, if any head is valid:
//    the winner pops; CDB <= {tag,data} of the winner; conf <= one-hot(winner).
//    Otherwise CDB <= 0 and conf <= 0.
//  Exactly one broadcast per cycle; CDB and conf are held for one cycle only.
//  Latency: a push at edge k into an empty FIFO is visible on CDB after edge k+1 at the earliest (no bypass).
//  Simultaneous push and pop on the same non-full FIFO is allowed; occupancy is unchanged.
//  FIFO pointers: log2(DEPTH) bits with natural wrap; count is log2(DEPTH)+1 bits.
//  No starvation: ages are unique per issued instruction, so a pending result is eventually the oldest.
// STRUCTURE
//  tomasulo_pkg: TAG_W, DATA_W, AGE_W, CDB_W=TAG_W+DATA_W, TAG_NONE=3'b000, station tags 1..4,
//    function age_older(a,b).
//  Sub-module cdb_src_fifo: one per source; DEPTH-entry, holds {tag,data,age};
//    ports push, pop, head, empty, full.
//  Top: N_SRC fifo instances, combinational oldest-select, CDB/conf/ovf registers.
// TESTING
//  1. Reset: CLR pulse mid-stream with 2 entries buffered -> CDB=0, conf=0, ovf=0, full=0; nothing broadcast after release.
//  2. Single result: src0 req tag=1 data=16'h00A5 age=5 at edge k -> CDB=19'h100A5 after edge k+1,
//     conf=2'b01 for one cycle, then CDB=0.
//  3. Age arbitration: same edge src0 (tag2,age=9) and src1 (tag3,age=7) -> tag3 first, then tag2 next cycle.
//     Equal ages -> src0 first.
//  4. Wrap: src0 age=10'h3FE, src1 age=10'h001 -> src0 broadcast first.
//  5. Full/overflow: DEPTH=2, hold src1 out of arbitration by keeping src0 older, push 3 to src1 -> full[1]=1 after 2,
//     third dropped, ovf=1; later exactly 2 src1 broadcasts.
//  6. Tag 0 and idle: req tag=0 -> no push, CDB stays 0, ovf stays 0.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared widths, tags, entry type and age compare for the issue/return path
package tomasulo_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 16;
    localparam int AGE_W  = 10;
    localparam int CDB_W  = TAG_W + DATA_W;

    localparam logic [TAG_W-1:0] TAG_NONE = 3'b000;
    localparam logic [TAG_W-1:0] TAG_RS1  = 3'd1;
    localparam logic [TAG_W-1:0] TAG_RS2  = 3'd2;
    localparam logic [TAG_W-1:0] TAG_RS3  = 3'd3;
    localparam logic [TAG_W-1:0] TAG_RS4  = 3'd4;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [AGE_W-1:0]  age;
    } cdb_entry_t;

    // Issue counter wraps, so "older" is decided by the sign of the modular difference.
    function automatic logic age_older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] diff;
        diff = a - b;
        return diff[AGE_W-1];
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-source result FIFO holding {tag,data,age}
module cdb_src_fifo
    import tomasulo_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       push,
    input  cdb_entry_t push_entry,
    input  logic       pop,
    output cdb_entry_t head,
    output logic       empty,
    output logic       full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

    cdb_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - buffers FU results and broadcasts the oldest one per cycle on the CDB
module cdb_arbiter
    import tomasulo_pkg::*;
#(
    parameter int N_SRC = 2,
    parameter int DEPTH = 2
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic [N_SRC-1:0]        req,
    input  logic [N_SRC*TAG_W-1:0]  req_tag,
    input  logic [N_SRC*DATA_W-1:0] req_data,
    input  logic [N_SRC*AGE_W-1:0]  req_age,
    output logic [N_SRC-1:0]        full,
    output logic [N_SRC-1:0]        conf,
    output logic [CDB_W-1:0]        CDB,
    output logic                    ovf
);

    logic [N_SRC-1:0] push;
    logic [N_SRC-1:0] drop;
    logic [N_SRC-1:0] pop;
    logic [N_SRC-1:0] empty;
    cdb_entry_t       head [N_SRC];

    logic             any_valid;
    logic [N_SRC-1:0] win_oh;
    cdb_entry_t       win_entry;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        cdb_entry_t in_entry;
        logic       tag_live;

        assign in_entry.tag  = req_tag[gi*TAG_W +: TAG_W];
        assign in_entry.data = req_data[gi*DATA_W +: DATA_W];
        assign in_entry.age  = req_age[gi*AGE_W +: AGE_W];
        assign tag_live      = (in_entry.tag != TAG_NONE);
        // full reflects occupancy before this edge's pop, so a same-edge pop never rescues a push.
        assign push[gi]      = req[gi] && tag_live && !full[gi];
        assign drop[gi]      = req[gi] && tag_live && full[gi];

        cdb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
            .CLK        (CLK),
            .CLR        (CLR),
            .push       (push[gi]),
            .push_entry (in_entry),
            .pop        (pop[gi]),
            .head       (head[gi]),
            .empty      (empty[gi]),
            .full       (full[gi])
        );
    end

    // Strictly-older replacement while scanning upward keeps the lowest index on equal ages.
    always_comb begin
        any_valid = 1'b0;
        win_oh    = '0;
        win_entry = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!empty[i] && (!any_valid || age_older(head[i].age, win_entry.age))) begin
                any_valid = 1'b1;
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_entry = head[i];
            end
        end
    end

    assign pop = win_oh;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            CDB  <= '0;
            conf <= '0;
            ovf  <= 1'b0;
        end else begin
            CDB  <= any_valid ? {win_entry.tag, win_entry.data} : '0;
            conf <= win_oh;
            ovf  <= ovf | (|drop);
        end
    end

endmodule
